// File: rtl/ysyx_23060236_radix2_div_if.sv
// rtl/ysyx_23060236_radix2_div_if.sv - EXU <-> divider request/response handshake bundle
interface ysyx_23060236_radix2_div_if;
    logic        div_valid;
    logic        div_ready;
    logic        div_sign;
    logic [31:0] div1;
    logic [31:0] div2;
    logic [31:0] res;
    logic [31:0] rem;
    logic        div_outvalid;

    modport master (
        output div_valid, div_sign, div1, div2,
        input  div_ready, res, rem, div_outvalid
    );

    modport slave (
        input  div_valid, div_sign, div1, div2,
        output div_ready, res, rem, div_outvalid
    );
endinterface

// File: rtl/ysyx_23060236_radix2_div.sv
// rtl/ysyx_23060236_radix2_div.sv - 32-bit restoring divider, RV-M semantics; YSYX_23060236_DIV_FASTPATH_EN bypasses CALC for div-by-zero/overflow
module ysyx_23060236_radix2_div (
    input  logic                           clock,
    input  logic                           reset,
    ysyx_23060236_radix2_div_if.slave      bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] prem;
    logic [31:0] quo;
    logic [31:0] dsr;
    logic [5:0]  cnt;
    logic        q_neg;
    logic        r_neg;
    logic        dz;
    logic        fast_hit;

    logic        handshake;
    logic        special;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [32:0] shifted;
    logic [32:0] diff;

    assign handshake = bus.div_valid & bus.div_ready;
    assign bus.div_ready = (state == IDLE) & ~bus.div_outvalid;

    assign mag_a = (bus.div_sign & bus.div1[31]) ? (32'd0 - bus.div1) : bus.div1;
    assign mag_b = (bus.div_sign & bus.div2[31]) ? (32'd0 - bus.div2) : bus.div2;

`ifdef YSYX_23060236_DIV_FASTPATH_EN
    assign special = (bus.div2 == 32'd0) |
                     (bus.div_sign & (bus.div1 == 32'h8000_0000) & (bus.div2 == 32'hFFFF_FFFF));
`else
    assign special = 1'b0;
`endif

    // Quotient register doubles as the dividend shifter: dividend bits leave at the top, quotient bits enter at the bottom.
    assign shifted = {prem, quo[31]};
    assign diff    = shifted - {1'b0, dsr};

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (handshake) begin
                    state_next = special ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt == 6'd31) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prem             <= 32'd0;
            quo              <= 32'd0;
            dsr              <= 32'd0;
            cnt              <= 6'd0;
            q_neg            <= 1'b0;
            r_neg            <= 1'b0;
            dz               <= 1'b0;
            fast_hit         <= 1'b0;
            bus.res          <= 32'd0;
            bus.rem          <= 32'd0;
            bus.div_outvalid <= 1'b0;
        end else begin
            bus.div_outvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (handshake) begin
                        q_neg    <= bus.div_sign & (bus.div1[31] ^ bus.div2[31]);
                        r_neg    <= bus.div_sign & bus.div1[31];
                        dz       <= (bus.div2 == 32'd0);
                        dsr      <= mag_b;
                        quo      <= mag_a;
                        prem     <= 32'd0;
                        cnt      <= 6'd0;
                        fast_hit <= special;
`ifdef YSYX_23060236_DIV_FASTPATH_EN
                        if (special) begin
                            bus.div_outvalid <= 1'b1;
                            if (bus.div2 == 32'd0) begin
                                bus.res <= 32'hFFFF_FFFF;
                                bus.rem <= bus.div1;
                            end else begin
                                bus.res <= 32'h8000_0000;
                                bus.rem <= 32'd0;
                            end
                        end
`endif
                    end
                end
                CALC: begin
                    cnt <= cnt + 6'd1;
                    if (!diff[32]) begin
                        prem <= diff[31:0];
                        quo  <= {quo[30:0], 1'b1};
                    end else begin
                        prem <= shifted[31:0];
                        quo  <= {quo[30:0], 1'b0};
                    end
                end
                DONE: begin
                    // Fast-path results were already registered on the handshake edge.
                    if (!fast_hit) begin
                        bus.div_outvalid <= 1'b1;
                        // The raw signed path would negate an all-ones quotient to 1 on divide-by-zero.
                        if (dz) begin
                            bus.res <= 32'hFFFF_FFFF;
                        end else begin
                            bus.res <= q_neg ? (32'd0 - quo) : quo;
                        end
                        bus.rem <= r_neg ? (32'd0 - prem) : prem;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_23060236_radix2_div.sv
// tb/tb_ysyx_23060236_radix2_div.sv - self-checking bench for the radix-2 divider against an arithmetic reference
module tb_ysyx_23060236_radix2_div;
    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    ysyx_23060236_radix2_div_if dif ();

    ysyx_23060236_radix2_div dut (
        .clock (clock),
        .reset (reset),
        .bus   (dif)
    );

`ifdef YSYX_23060236_DIV_FASTPATH_EN
    localparam int FAST_LAT = 1;
`else
    localparam int FAST_LAT = 34;
`endif
    localparam int FULL_LAT = 34;

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // RISC-V M semantics straight from the arithmetic rules.
    task automatic model(input logic sign, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic special);
        int sa;
        int sb;
        sa = a;
        sb = b;
        special = 1'b0;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            special = 1'b1;
        end else if (sign && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
            special = 1'b1;
        end else if (sign) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    // Entered and left at a negedge; the next call therefore issues back-to-back.
    task automatic run_op(input string tag, input logic sign, input logic [31:0] a,
                          input logic [31:0] b, input logic poke);
        logic [31:0] q;
        logic [31:0] r;
        logic        special;
        int          lat;
        int          cyc;
        logic        ready_ok;
        model(sign, a, b, q, r, special);
        lat = special ? FAST_LAT : FULL_LAT;
        check({tag, ".ready_in"}, {31'd0, dif.div_ready}, 32'd1);
        dif.div_valid = 1'b1;
        dif.div_sign  = sign;
        dif.div1      = a;
        dif.div2      = b;
        @(negedge clock);
        dif.div_valid = 1'b0;
        dif.div_sign  = ~sign;
        dif.div1      = $urandom;
        dif.div2      = $urandom;
        cyc      = 1;
        ready_ok = 1'b1;
        while (!dif.div_outvalid && cyc < 40) begin
            if (dif.div_ready) ready_ok = 1'b0;
            if (poke && cyc == 5) begin
                dif.div_valid = 1'b1;
                dif.div2      = 32'd3;
            end
            @(negedge clock);
            dif.div_valid = 1'b0;
            cyc++;
        end
        if (dif.div_ready) ready_ok = 1'b0;
        check({tag, ".latency"}, cyc, lat);
        check({tag, ".ready_busy"}, {31'd0, ready_ok}, 32'd1);
        check({tag, ".res"}, dif.res, q);
        check({tag, ".rem"}, dif.rem, r);
        @(negedge clock);
        check({tag, ".pulse_end"}, {31'd0, dif.div_outvalid}, 32'd0);
        check({tag, ".ready_after"}, {31'd0, dif.div_ready}, 32'd1);
        check({tag, ".res_held"}, dif.res, q);
    endtask

    initial begin
        logic        sign;
        logic [31:0] a;
        logic [31:0] b;
        int          seen;

        reset         = 1'b1;
        dif.div_valid = 1'b0;
        dif.div_sign  = 1'b0;
        dif.div1      = 32'd0;
        dif.div2      = 32'd0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check("reset.ready", {31'd0, dif.div_ready}, 32'd1);
        check("reset.outvalid", {31'd0, dif.div_outvalid}, 32'd0);
        check("reset.res", dif.res, 32'd0);
        check("reset.rem", dif.rem, 32'd0);

        run_op("u100_7", 1'b0, 32'd100, 32'd7, 1'b0);
        run_op("s-7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("s7_-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);
        run_op("sdz", 1'b1, 32'h8000_0005, 32'd0, 1'b0);
        run_op("udz", 1'b0, 32'd9, 32'd0, 1'b0);
        run_op("sovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("uovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("poke", 1'b0, 32'hDEAD_BEEF, 32'd1234, 1'b1);
        run_op("smin_1", 1'b1, 32'h8000_0000, 32'd1, 1'b0);

        for (int i = 0; i < 16; i++) begin
            sign = 1'($urandom_range(0, 1));
            a    = $urandom;
            case ($urandom_range(0, 3))
                0:       b = $urandom;
                1:       b = $urandom_range(1, 20);
                2:       b = 32'd0;
                default: b = 32'hFFFF_FFFF - $urandom_range(0, 3);
            endcase
            run_op($sformatf("rnd%0d", i), sign, a, b, 1'($urandom_range(0, 1)));
        end

        // Reset in C10 of an in-flight operation.
        dif.div_valid = 1'b1;
        dif.div_sign  = 1'b0;
        dif.div1      = 32'd1000;
        dif.div2      = 32'd3;
        @(negedge clock);
        dif.div_valid = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("rst_mid.ready", {31'd0, dif.div_ready}, 32'd1);
        check("rst_mid.res", dif.res, 32'd0);
        check("rst_mid.rem", dif.rem, 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (dif.div_outvalid) seen++;
            @(negedge clock);
        end
        check("rst_mid.no_pulse", seen, 0);
        check("rst_mid.ready_late", {31'd0, dif.div_ready}, 32'd1);

        run_op("post_rst", 1'b1, 32'hFFFF_FF9C, 32'd7, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/ysyx_23060236_radix2_div.md
# ysyx_23060236_radix2_div

Iterative 32-bit radix-2 restoring divider: the responder side of the EXU's divide handshake. It accepts one DIV/DIVU/REM/REMU operation per request, computes quotient and remainder over multiple cycles, and signals completion with a one-cycle `div_outvalid` pulse. The EXU selects quotient or remainder from `res`/`rem` using its registered funct3. Results follow RISC-V M-extension semantics, including divide-by-zero and signed overflow.

## Interface
- No parameters; width fixed at 32.
- `clock`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `div_valid`  in  1  request; operands sampled when `div_valid & div_ready`
- `div_ready`  out  1  idle, can accept a request
- `div_sign`  in  1  1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU)
- `div1`  in  32  dividend
- `div2`  in  32  divisor
- `res`  out  32  quotient, valid while `div_outvalid`=1, held afterwards
- `rem`  out  32  remainder, same validity as `res`
- `div_outvalid`  out  1  single-cycle completion pulse

## Operation
- FSM states: IDLE, CALC, DONE.
  - IDLE: `div_ready`=1. On handshake:
    - latch the sign flags: quotient negative = `div_sign & (div1[31]^div2[31])`; remainder negative = `div_sign & div1[31]`.
    - latch the magnitudes |div1| and |div2|; the magnitude is the operand itself when `div_sign`=0.
    - clear the 6-bit step counter and go to CALC.
  - CALC: one quotient bit per cycle, MSB first.
    - Partial remainder is 33 bits: shift left by one and bring in the next dividend bit.
    - Trial-subtract the divisor magnitude zero-extended to 33 bits.
    - If the result is non-negative, keep the difference and set the quotient bit to 1; otherwise restore and set it to 0.
    - After 32 steps go to DONE.
  - DONE: apply sign correction (two's-complement negate of quotient and/or remainder per the latched flags). Register the results into `res`/`rem` and pulse `div_outvalid`=1 for one cycle, then return to IDLE.
- 0x80000000 has magnitude 0x80000000 (unsigned 32-bit); no 33-bit operand path is needed.
- Special results, in all modes:
  - Divisor 0 → `res`=0xFFFFFFFF, `rem`=div1.
  - Signed 0x80000000 / 0xFFFFFFFF → `res`=0x80000000, `rem`=0. The normal algorithm produces this.
  - Divisor 0 must be forced: the signed raw path would negate the quotient to 1.
- `div_valid` while busy: ignored, no queueing.
- `res`/`rem` change only on completion.

## Timing
- Reset values: `div_ready`=1, `div_outvalid`=0, `res`=0, `rem`=0, FSM=IDLE, counter=0.
- Handshake in cycle C0. `div_ready`=0 from C1 until the `div_outvalid` cycle, inclusive. `div_ready`=1 the cycle after.
- Normal latency: `div_outvalid` in cycle C34 (32 CALC cycles + DONE).
- `div_outvalid` is never high for two consecutive cycles.
- A new request can be accepted one cycle after `div_outvalid`.
- Reset mid-operation: FSM returns to IDLE next cycle, no `div_outvalid`, `res`/`rem` cleared to 0.

## Configuration
- `YSYX_23060236_DIV_FASTPATH_EN` defined:
  - divisor 0 and signed overflow bypass CALC.
  - The FSM goes IDLE→DONE directly, and `div_outvalid` is asserted in C1.
- Not defined:
  - every operation takes the full C34 latency.
  - The divisor-0 quotient override is still applied in DONE, so results are identical in both builds.

## Test plan
- Unsigned 100 / 7, `div_sign`=0 → C34: `res`=14, `rem`=2, `div_ready`=0 for C1–C34.
- Signed -7 / 2 → `res`=0xFFFFFFFD, `rem`=0xFFFFFFFF.
- Signed 7 / -2 → `res`=0xFFFFFFFD, `rem`=1.
- Divide by zero:
  - Signed 0x80000005 / 0 → `res`=0xFFFFFFFF, `rem`=0x80000005.
  - Unsigned 9 / 0 → `res`=0xFFFFFFFF, `rem`=9.
  - Pulse at C1 with FASTPATH_EN defined, C34 without.
- Signed 0x80000000 / 0xFFFFFFFF → `res`=0x80000000, `rem`=0; C1 or C34 per macro.
- Handshake and reset behaviour:
  - Assert `reset` in C10 of an operation → no pulse, `div_ready`=1 afterwards.
  - A second `div_valid` during CALC is ignored.
  - A back-to-back request one cycle after `div_outvalid` is accepted and completes 34 cycles later.
